// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
// The optional saturation feature (macro ADDSUB_SAT_EN) lives in addsub_chunked.sv.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default geometry of the unit.
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_CHUNK  = 4;

  // Number of chunks processed for a given operand width.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; at least one bit so NCHUNK=1 still has a register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int DEF_IDX_W  = idx_w(DEF_NCHUNK);

endpackage

// File: rtl/addsub_chunked_if.sv
// Operand/result bundle of the chunked adder/subtractor.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1; the producer holds its payload stable while
// valid=1 and ready=0.
interface addsub_chunked_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder. c_msb is the carry into the top bit,
// which together with cout gives signed overflow for the most significant chunk.
module addsub_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  // Bit-serial ripple through the chunk.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/addsub_chunked.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock from the
// LSB chunk up. Subtraction stores ~b and seeds the carry with 1.
// Optional: define ADDSUB_SAT_EN to clamp the result on signed overflow.
module addsub_chunked
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic   clk,
  input  logic   rst,
  addsub_chunked_if.slave bus,
  output state_t dbg_state
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q, cy_q, ov_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic             cout_c, cmsb_c;
  logic             accept, last;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == RUN) && (idx_q == LAST);

  // Select the operand chunk currently being added.
  always_comb begin
    a_c = a_q[idx_q*CHUNK +: CHUNK];
    b_c = b_q[idx_q*CHUNK +: CHUNK];
  end

  addsub_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a     (a_c),
    .b     (b_c),
    .cin   (carry_q),
    .sum   (s_c),
    .cout  (cout_c),
    .c_msb (cmsb_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode: accept in IDLE, walk chunks in RUN, wait for consumer in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (idx_q == LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-chunk result write-back and final flag latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      idx_q   <= '0;
    end else if (state == RUN) begin
      res_q[idx_q*CHUNK +: CHUNK] <= s_c;
      carry_q <= cout_c;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        cy_q <= cout_c;
        ov_q <= cout_c ^ cmsb_c;
`ifdef ADDSUB_SAT_EN
        // Clamp toward the sign of A; overriding the chunk write above.
        if (cout_c ^ cmsb_c)
          res_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cy_q;
  assign bus.overflow  = ov_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_addsub_chunked.sv
// Table-driven bench for addsub_chunked at CHUNK=4, 16 and 1 (WIDTH=16),
// plus hand-written backpressure and mid-operation reset sequences.
module tb_addsub_chunked;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus, routed to the selected DUT.
  logic        in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  int          sel = 0;

  addsub_chunked_if #(.WIDTH(16)) if4 ();
  addsub_chunked_if #(.WIDTH(16)) if16 ();
  addsub_chunked_if #(.WIDTH(16)) if1 ();
  state_t st4, st16, st1;

  assign if4.in_valid  = in_valid && (sel == 0);
  assign if16.in_valid = in_valid && (sel == 1);
  assign if1.in_valid  = in_valid && (sel == 2);
  assign if4.a = a;  assign if16.a = a;  assign if1.a = a;
  assign if4.b = b;  assign if16.b = b;  assign if1.b = b;
  assign if4.sub = sub;  assign if16.sub = sub;  assign if1.sub = sub;
  assign if4.out_ready  = out_ready && (sel == 0);
  assign if16.out_ready = out_ready && (sel == 1);
  assign if1.out_ready  = out_ready && (sel == 2);

  addsub_chunked #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(if4),  .dbg_state(st4));
  addsub_chunked #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(if16), .dbg_state(st16));
  addsub_chunked #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(if1),  .dbg_state(st1));

  // Outputs of the selected DUT.
  logic        o_valid, o_ready, o_cy, o_ov;
  logic [15:0] o_res;
  state_t      o_state;
  always_comb begin
    o_valid = if4.out_valid; o_ready = if4.in_ready; o_res = if4.result;
    o_cy = if4.carry_out; o_ov = if4.overflow; o_state = st4;
    if (sel == 1) begin
      o_valid = if16.out_valid; o_ready = if16.in_ready; o_res = if16.result;
      o_cy = if16.carry_out; o_ov = if16.overflow; o_state = st16;
    end else if (sel == 2) begin
      o_valid = if1.out_valid; o_ready = if1.in_ready; o_res = if1.result;
      o_cy = if1.carry_out; o_ov = if1.overflow; o_state = st1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sel=%0d actual=%h required=%h", name, sel, act, exp);
    end
  endtask

  // Drive one operation through the selected DUT and collect its result.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                        input int exp_lat, output logic [15:0] r, output logic c,
                        output logic o);
    int n;
    n = 0;
    while (!o_ready && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    check("in_ready_idle", 32'(o_ready), 32'd1);
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", 32'(o_ready), 32'd0);
    n = 0;
    while (!o_valid && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    check("latency", 32'(n), 32'(exp_lat));
    r = o_res; c = o_cy; o = o_ov;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(o_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res_wrap;
    logic [15:0] res_sat;
    logic        cy;
    logic        ov;
  } vec_t;

  vec_t vecs[12];
  int   lat[3];

  initial begin
    logic [15:0] r;
    logic        c, o;
    logic [15:0] hold_res;
    int          n;

    vecs[0]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[10] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 16'hBE01, 1'b0, 1'b0};
    vecs[11] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
    lat[0] = 4; lat[1] = 1; lat[2] = 16;

    // Reset state while rst is held.
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_out_valid", 32'(o_valid), 32'd0);
      check("rst_in_ready", 32'(o_ready), 32'd1);
      check("rst_result", 32'(o_res), 32'd0);
      check("rst_flags", {30'd0, o_cy, o_ov}, 32'd0);
      check("rst_state", 32'(o_state), 32'(IDLE));
    end
    sel = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Vector table on every chunk geometry.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 12; i++) begin
`ifdef ADDSUB_SAT_EN
        exp_q.push_back({15'd0, vecs[i].cy, vecs[i].ov, vecs[i].res_sat});
`else
        exp_q.push_back({15'd0, vecs[i].cy, vecs[i].ov, vecs[i].res_wrap});
`endif
        run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat[s], r, c, o);
        check($sformatf("vec%0d", i), {15'd0, c, o, r}, exp_q.pop_front());
      end
    end

    // Backpressure with a second request held during RUN/DONE.
    sel = 0;
    a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    a = 16'h0007; b = 16'h0005; sub = 1'b1;  // stays asserted, must be ignored
    n = 0;
    while (!o_valid && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    check("bp_latency", 32'(n), 32'd4);
    hold_res = 16'h2345;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check("bp_result", 32'(o_res), 32'(hold_res));
      check("bp_flags", {30'd0, o_cy, o_ov}, 32'd0);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_in_ready", 32'(o_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("bp_back_idle", 32'(o_ready), 32'd1);
    @(posedge clk); @(negedge clk);  // held request accepted here
    in_valid = 1'b0;
    check("bp_second_accept", 32'(o_ready), 32'd0);
    n = 0;
    while (!o_valid && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    check("bp_second_latency", 32'(n), 32'd4);
    check("bp_second_result", {15'd0, o_cy, o_ov, o_res}, {15'd0, 1'b1, 1'b0, 16'h0002});
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;

    // Reset after two RUN cycles abandons the operation.
    a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("mid_state_run", 32'(o_state), 32'(RUN));
    rst = 1'b1; #1;
    check("mid_rst_out_valid", 32'(o_valid), 32'd0);
    check("mid_rst_in_ready", 32'(o_ready), 32'd1);
    check("mid_rst_result", 32'(o_res), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 4, r, c, o);
    check("post_rst_op", {15'd0, c, o, r}, {15'd0, 1'b1, 1'b0, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
